// File: rtl/riscv_imem_prefetch_if.sv
// Fetch-side bundle for the instruction prefetcher: CPU request/head port plus the BIU read channel.
// The master modport is the prefetcher's view; slave is the view of the CPU/BIU environment.
interface riscv_imem_prefetch_if #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned PLEN        = 34,
  parameter int unsigned PARCEL_SIZE = 32,
  parameter int unsigned BIUTAG_SIZE = 2
);
  localparam int unsigned PV_W = XLEN / PARCEL_SIZE;

  logic [1:0]             st_prv_i;
  logic                   mem_req_i;
  logic                   mem_ack_o;
  logic                   mem_flush_i;
  logic [XLEN-1:0]        mem_adr_i;
  logic [XLEN-1:0]        parcel_o;
  logic [PV_W-1:0]        parcel_valid_o;
  logic                   mem_error_o;
  logic                   mem_misaligned_o;
  logic                   biu_stb_o;
  logic                   biu_stb_ack_i;
  logic [PLEN-1:0]        biu_adri_o;
  logic [2:0]             biu_size_o;
  logic [2:0]             biu_type_o;
  logic                   biu_we_o;
  logic                   biu_lock_o;
  logic [2:0]             biu_prot_o;
  logic [XLEN-1:0]        biu_d_o;
  logic [XLEN-1:0]        biu_q_i;
  logic                   biu_ack_i;
  logic                   biu_err_i;
  logic [BIUTAG_SIZE-1:0] biu_tagi_o;
  logic [BIUTAG_SIZE-1:0] biu_tago_i;

  modport master (
    input  st_prv_i, mem_req_i, mem_flush_i, mem_adr_i,
    input  biu_stb_ack_i, biu_q_i, biu_ack_i, biu_err_i, biu_tago_i,
    output mem_ack_o, parcel_o, parcel_valid_o, mem_error_o, mem_misaligned_o,
    output biu_stb_o, biu_adri_o, biu_size_o, biu_type_o, biu_we_o, biu_lock_o,
    output biu_prot_o, biu_d_o, biu_tagi_o
  );

  modport slave (
    output st_prv_i, mem_req_i, mem_flush_i, mem_adr_i,
    output biu_stb_ack_i, biu_q_i, biu_ack_i, biu_err_i, biu_tago_i,
    input  mem_ack_o, parcel_o, parcel_valid_o, mem_error_o, mem_misaligned_o,
    input  biu_stb_o, biu_adri_o, biu_size_o, biu_type_o, biu_we_o, biu_lock_o,
    input  biu_prot_o, biu_d_o, biu_tagi_o
  );
endinterface

// File: rtl/riscv_imem_prefetch.sv
// Uncached sequential instruction prefetcher: keeps up to MAX_OUTSTANDING BIU reads in flight
// into a DEPTH-entry queue and uses an epoch tag to drop returns that predate a flush.
module riscv_imem_prefetch #(
  parameter int unsigned XLEN            = 32,
  parameter int unsigned PLEN            = 34,
  parameter int unsigned PARCEL_SIZE     = 32,
  parameter int unsigned HAS_RVC         = 0,
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned BIUTAG_SIZE     = 2
) (
  input  logic                   rst_ni,
  input  logic                   clk_i,
  riscv_imem_prefetch_if.master  bus
);
  localparam int unsigned PV_W   = XLEN / PARCEL_SIZE;
  localparam int unsigned BPW    = XLEN / 8;
  localparam int unsigned PSH    = $clog2(PARCEL_SIZE / 8);
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
  localparam int unsigned OFF_W  = 3;

  localparam logic [2:0] SIZE_WORD      = 3'b010;
  localparam logic [2:0] SIZE_DWORD     = 3'b011;
  localparam logic [2:0] TYPE_SINGLE    = 3'b000;
  localparam logic [2:0] PROT_INSTR     = 3'b001;
  localparam logic [2:0] PROT_PRIV      = 3'b010;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HALT} state_e;

  state_e                 state_q, state_d;
  logic [BIUTAG_SIZE-1:0] epoch_q, epoch_d;
  logic [XLEN-1:0]        fetch_adr_q, fetch_adr_d;
  logic [OFF_W-1:0]       offset_q, offset_d;
  logic                   first_q, first_d;
  logic [CNT_W-1:0]       outst_q, outst_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;

  logic [XLEN-1:0]        data_q [DEPTH];
  logic [PV_W-1:0]        pv_q   [DEPTH];
  logic                   err_q  [DEPTH];
  logic                   mis_q  [DEPTH];

  logic                   stb_c, accept_c, ret_c, pop_c, head_vld_c, mis_c;
  logic                   push_c, push_err_c, push_mis_c;
  logic [PTR_W-1:0]       push_idx_c;
  logic [XLEN-1:0]        push_data_c;
  logic [PV_W-1:0]        push_pv_c, pv_first_c;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      epoch_q     <= '0;
      fetch_adr_q <= '0;
      offset_q    <= '0;
      first_q     <= 1'b0;
      outst_q     <= '0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      epoch_q     <= epoch_d;
      fetch_adr_q <= fetch_adr_d;
      offset_q    <= offset_d;
      first_q     <= first_d;
      outst_q     <= outst_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  // Queue storage; only the push slot is written each cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        pv_q[i]   <= '0;
        err_q[i]  <= 1'b0;
        mis_q[i]  <= 1'b0;
      end
    end else if (push_c) begin
      data_q[push_idx_c] <= push_data_c;
      pv_q[push_idx_c]   <= push_pv_c;
      err_q[push_idx_c]  <= push_err_c;
      mis_q[push_idx_c]  <= push_mis_c;
    end
  end

  always_comb begin
    state_d     = state_q;
    epoch_d     = epoch_q;
    fetch_adr_d = fetch_adr_q;
    offset_d    = offset_q;
    first_d     = first_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    push_c      = 1'b0;
    push_idx_c  = wr_ptr_q;
    push_data_c = bus.biu_q_i;
    push_err_c  = bus.biu_err_i;
    push_mis_c  = 1'b0;
    push_pv_c   = '1;

    head_vld_c  = (count_q != '0);
    // Credit: every in-flight read already owns a queue slot.
    stb_c       = (state_q == ST_RUN) && (outst_q < CNT_W'(MAX_OUTSTANDING)) &&
                  (((CNT_W+1)'(count_q) + (CNT_W+1)'(outst_q)) < (CNT_W+1)'(DEPTH));
    accept_c    = stb_c & bus.biu_stb_ack_i;
    ret_c       = bus.biu_ack_i | bus.biu_err_i;
    pop_c       = bus.mem_req_i & head_vld_c & ~bus.mem_flush_i;
    mis_c       = bus.mem_adr_i[0] | ((HAS_RVC == 0) && bus.mem_adr_i[1]);
    pv_first_c  = PV_W'({PV_W{1'b1}} << offset_q);

    outst_d = outst_q + CNT_W'(accept_c) - CNT_W'(ret_c);
    if (accept_c) fetch_adr_d = fetch_adr_q + XLEN'(BPW);

    if (bus.mem_flush_i) begin
      epoch_d     = epoch_q + 1'b1;
      fetch_adr_d = bus.mem_adr_i & ~XLEN'(BPW - 1);
      offset_d    = OFF_W'((bus.mem_adr_i[2:0] & 3'(BPW - 1)) >> PSH);
      first_d     = 1'b1;
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      count_d     = '0;
      if (mis_c) begin
        push_c      = 1'b1;
        push_idx_c  = '0;
        push_data_c = '0;
        push_err_c  = 1'b0;
        push_mis_c  = 1'b1;
        wr_ptr_d    = PTR_W'(1);
        count_d     = CNT_W'(1);
        first_d     = 1'b0;
        state_d     = ST_HALT;
      end else begin
        state_d = ST_RUN;
      end
    end else begin
      if (ret_c && (bus.biu_tago_i == epoch_q)) begin
        push_c   = 1'b1;
        push_pv_c = first_q ? pv_first_c : '1;
        first_d  = 1'b0;
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (bus.biu_err_i && (state_q == ST_RUN)) state_d = ST_HALT;
      end
      if (pop_c) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    end
  end

  assign bus.mem_ack_o        = pop_c;
  assign bus.parcel_o         = head_vld_c ? data_q[rd_ptr_q] : '0;
  assign bus.parcel_valid_o   = head_vld_c ? pv_q[rd_ptr_q]   : '0;
  assign bus.mem_error_o      = head_vld_c & err_q[rd_ptr_q];
  assign bus.mem_misaligned_o = head_vld_c & mis_q[rd_ptr_q];

  assign bus.biu_stb_o  = stb_c;
  assign bus.biu_adri_o = PLEN'(fetch_adr_q);
  assign bus.biu_size_o = (XLEN == 64) ? SIZE_DWORD : SIZE_WORD;
  assign bus.biu_type_o = TYPE_SINGLE;
  assign bus.biu_we_o   = 1'b0;
  assign bus.biu_lock_o = 1'b0;
  assign bus.biu_prot_o = PROT_INSTR | ((bus.st_prv_i == 2'b00) ? 3'b000 : PROT_PRIV);
  assign bus.biu_d_o    = '0;
  assign bus.biu_tagi_o = epoch_q;
endmodule

// File: tb/tb_riscv_imem_prefetch.sv
// Randomized bench for riscv_imem_prefetch: a queue-based reference model and BIU responder,
// plus a short directed check of a 16-bit-parcel instance.
module tb_riscv_imem_prefetch;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned MAXO  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  riscv_imem_prefetch_if #(.XLEN(32), .PLEN(34), .PARCEL_SIZE(32), .BIUTAG_SIZE(2)) bus ();
  riscv_imem_prefetch_if #(.XLEN(32), .PLEN(34), .PARCEL_SIZE(16), .BIUTAG_SIZE(2)) bus2 ();

  riscv_imem_prefetch #(.XLEN(32), .PLEN(34), .PARCEL_SIZE(32), .HAS_RVC(0), .DEPTH(DEPTH),
                        .MAX_OUTSTANDING(MAXO), .BIUTAG_SIZE(2))
    dut (.rst_ni(rst_n), .clk_i(clk), .bus(bus));

  riscv_imem_prefetch #(.XLEN(32), .PLEN(34), .PARCEL_SIZE(16), .HAS_RVC(1), .DEPTH(DEPTH),
                        .MAX_OUTSTANDING(MAXO), .BIUTAG_SIZE(2))
    dut2 (.rst_ni(rst_n), .clk_i(clk), .bus(bus2));

  typedef struct { logic [31:0] data; bit err; bit mis; } ent_t;
  typedef struct { logic [31:0] adr; int unsigned ep; } req_t;

  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;

  ent_t        mq[$];
  req_t        pend[$];
  int          mode;          // 0 idle, 1 fetching, 2 halted
  int unsigned m_ep;
  logic [31:0] m_fetch;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'hA5C3_0F96;
  endfunction

  // One clock of stimulus: drive at negedge, check settled outputs, advance the model.
  task automatic step(input bit req, input bit flush, input logic [31:0] adr,
                      input int ack_pct, input int ret_pct, input int err_pct);
    bit do_ret, do_err, exp_stb, exp_ack, acc;
    req_t r;
    @(negedge clk);
    do_ret = (pend.size() != 0) && ($urandom_range(0, 99) < ret_pct);
    do_err = do_ret && ($urandom_range(0, 99) < err_pct);
    bus.mem_req_i     = req;
    bus.mem_flush_i   = flush;
    bus.mem_adr_i     = adr;
    bus.biu_stb_ack_i = ($urandom_range(0, 99) < ack_pct);
    bus.biu_ack_i     = do_ret && !do_err;
    bus.biu_err_i     = do_err;
    bus.biu_q_i       = do_ret ? mem_word(pend[0].adr) : $urandom;
    bus.biu_tago_i    = do_ret ? 2'(pend[0].ep) : 2'($urandom);
    #1;
    exp_stb = (mode == 1) && (pend.size() < MAXO) && (mq.size() + pend.size() < DEPTH);
    check("stb", 64'(bus.biu_stb_o), 64'(exp_stb));
    if (exp_stb) check("adr", 64'(bus.biu_adri_o), {32'h0, m_fetch});
    check("tagi", 64'(bus.biu_tagi_o), 64'(m_ep));
    exp_ack = req && (mq.size() != 0) && !flush;
    check("ack", 64'(bus.mem_ack_o), 64'(exp_ack));
    if (mq.size() != 0) begin
      check("data", 64'(bus.parcel_o), 64'(mq[0].data));
      check("err", 64'(bus.mem_error_o), 64'(mq[0].err));
      check("mis", 64'(bus.mem_misaligned_o), 64'(mq[0].mis));
      check("pv", 64'(bus.parcel_valid_o), 64'(1));
    end
    acc = exp_stb && bus.biu_stb_ack_i;
    if (acc) acc_cnt++;
    if (do_ret) begin
      r = pend.pop_front();
      if (!flush && r.ep == m_ep) begin
        mq.push_back(ent_t'{data: mem_word(r.adr), err: do_err, mis: 1'b0});
        if (do_err && mode == 1) mode = 2;
      end
    end
    if (acc) begin
      pend.push_back(req_t'{adr: m_fetch, ep: m_ep});
      m_fetch = m_fetch + 32'd4;
    end
    if (exp_ack) void'(mq.pop_front());
    if (flush) begin
      mq.delete();
      m_ep    = (m_ep + 1) % 4;
      m_fetch = adr & ~32'd3;
      if (adr[0] || adr[1]) begin
        mq.push_back(ent_t'{data: 32'h0, err: 1'b0, mis: 1'b1});
        mode = 2;
      end else begin
        mode = 1;
      end
    end
  endtask

  logic [31:0] targets [8];

  initial begin
    targets = '{32'h100, 32'h200, 32'h300, 32'hFFFF_FFF8, 32'h102, 32'h101, 32'h7FC, 32'h8000_0000};
    bus.st_prv_i = 2'b11; bus.mem_req_i = 0; bus.mem_flush_i = 0; bus.mem_adr_i = '0;
    bus.biu_stb_ack_i = 0; bus.biu_q_i = '0; bus.biu_ack_i = 0; bus.biu_err_i = 0; bus.biu_tago_i = '0;
    bus2.st_prv_i = 2'b00; bus2.mem_req_i = 0; bus2.mem_flush_i = 0; bus2.mem_adr_i = '0;
    bus2.biu_stb_ack_i = 0; bus2.biu_q_i = '0; bus2.biu_ack_i = 0; bus2.biu_err_i = 0; bus2.biu_tago_i = '0;
    mode = 0; m_ep = 0; m_fetch = '0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_ack", 64'(bus.mem_ack_o), 64'(0));
    check("rst_stb", 64'(bus.biu_stb_o), 64'(0));
    check("rst_pv", 64'(bus.parcel_valid_o), 64'(0));
    check("rst_err", 64'(bus.mem_error_o), 64'(0));
    check("rst_mis", 64'(bus.mem_misaligned_o), 64'(0));
    check("rst_parcel", 64'(bus.parcel_o), 64'(0));
    check("rst_tagi", 64'(bus.biu_tagi_o), 64'(0));
    check("prot", 64'(bus.biu_prot_o), 64'(3'b011));
    check("size", 64'(bus.biu_size_o), 64'(3'b010));
    rst_n = 1'b1;

    // Idle: nothing issued without a flush
    repeat (3) step(1'b1, 1'b0, 32'h0, 100, 100, 0);
    // Zero-wait stream from 0x100
    step(1'b0, 1'b1, 32'h100, 100, 100, 0);
    repeat (12) step(1'b1, 1'b0, 32'h0, 100, 100, 0);
    // Fill with no consumer: exactly DEPTH accepts after the flush
    step(1'b0, 1'b1, 32'h400, 100, 100, 0);
    acc_cnt = 0;
    repeat (12) step(1'b0, 1'b0, 32'h0, 100, 100, 0);
    check("fill_accepts", 64'(acc_cnt), 64'(DEPTH));
    // Flush with reads in flight
    step(1'b0, 1'b1, 32'h100, 100, 100, 0);
    repeat (3) step(1'b1, 1'b0, 32'h0, 100, 0, 0);
    step(1'b1, 1'b1, 32'h200, 100, 100, 0);
    repeat (8) step(1'b1, 1'b0, 32'h0, 100, 100, 0);
    // Bus error halts fetching until a new flush
    repeat (2) step(1'b1, 1'b0, 32'h0, 100, 100, 100);
    repeat (6) step(1'b1, 1'b0, 32'h0, 100, 100, 0);
    step(1'b1, 1'b1, 32'h300, 100, 100, 0);
    repeat (6) step(1'b1, 1'b0, 32'h0, 100, 100, 0);
    // Misaligned target, then address wrap
    step(1'b0, 1'b1, 32'h102, 100, 100, 0);
    repeat (3) step(1'b0, 1'b0, 32'h0, 100, 100, 0);
    step(1'b1, 1'b1, 32'hFFFF_FFF8, 100, 100, 0);
    repeat (10) step(1'b1, 1'b0, 32'h0, 100, 100, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] t;
      t = targets[$urandom_range(0, 7)];
      if ($urandom_range(0, 3) == 0) t = $urandom & 32'hFFFF_FFFC;
      step($urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0, t,
           60, 60, 4);
    end

    // 16-bit parcels with RVC: first word after flush to 0x102 has only the upper parcel valid
    @(negedge clk);
    bus2.mem_flush_i = 1'b1; bus2.mem_adr_i = 32'h102;
    @(negedge clk);
    bus2.mem_flush_i = 1'b0;
    #1;
    check("rvc_stb", 64'(bus2.biu_stb_o), 64'(1));
    check("rvc_adr", 64'(bus2.biu_adri_o), 64'(34'h100));
    check("rvc_tagi", 64'(bus2.biu_tagi_o), 64'(1));
    check("rvc_mis", 64'(bus2.mem_misaligned_o), 64'(0));
    bus2.biu_stb_ack_i = 1'b1;
    @(negedge clk);
    bus2.biu_stb_ack_i = 1'b0;
    bus2.biu_ack_i = 1'b1; bus2.biu_q_i = 32'hCAFE_0100; bus2.biu_tago_i = 2'd1;
    @(negedge clk);
    bus2.biu_ack_i = 1'b0;
    #1;
    check("rvc_pv0", 64'(bus2.parcel_valid_o), 64'(2'b10));
    check("rvc_d0", 64'(bus2.parcel_o), 64'(32'hCAFE_0100));
    check("rvc_adr1", 64'(bus2.biu_adri_o), 64'(34'h104));
    bus2.biu_stb_ack_i = 1'b1;
    @(negedge clk);
    bus2.biu_stb_ack_i = 1'b0;
    bus2.biu_ack_i = 1'b1; bus2.biu_q_i = 32'hCAFE_0104; bus2.biu_tago_i = 2'd1;
    bus2.mem_req_i = 1'b1;
    #1;
    check("rvc_ack", 64'(bus2.mem_ack_o), 64'(1));
    @(negedge clk);
    bus2.biu_ack_i = 1'b0; bus2.mem_req_i = 1'b0;
    #1;
    check("rvc_pv1", 64'(bus2.parcel_valid_o), 64'(2'b11));
    check("rvc_d1", 64'(bus2.parcel_o), 64'(32'hCAFE_0104));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
